gtxe2_chnl_tx_oob_gen: RTL

GTXE2_CHNL_TX_OOB_GEN -- requirements
Module: gtxe2_chnl_tx_oob_gen

---
 rtl/gtxe2_chnl_tx_oob_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gtxe2_chnl_tx_oob_gen.sv
// SATA/SAS out-of-band signalling generator: emits COMINIT/COMWAKE/COMSAS burst
// sequences (ALIGN-like burst data separated by electrical-idle quiet gaps).
module gtxe2_chnl_tx_oob_gen #(
   parameter int         width              = 20,
   parameter logic [3:0] SATA_BURST_SEQ_LEN = 4'd6,
   parameter int         BURST_CYCLES       = 16,
   parameter int         QUIET_INIT_CYCLES  = 48,
   parameter int         QUIET_WAKE_CYCLES  = 16,
   parameter int         QUIET_SAS_CYCLES   = 144
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             TXCOMINIT,
   input  logic             TXCOMWAKE,
   input  logic             TXCOMSAS,
   output logic             TXCOMFINISH,
   input  logic             disparity,
   output logic [width-1:0] outdata,
   output logic             outval,
   output logic             txelecidle,
   output logic             busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_QUIET, ST_DONE} state_t;
   typedef enum logic [1:0] {MODE_NONE, MODE_INIT, MODE_WAKE, MODE_SAS} mode_t;

   localparam logic [15:0] BURST_LAST = 16'(BURST_CYCLES - 1);
   localparam logic [15:0] QI_LAST    = 16'(QUIET_INIT_CYCLES - 1);
   localparam logic [15:0] QW_LAST    = 16'(QUIET_WAKE_CYCLES - 1);
   localparam logic [15:0] QS_LAST    = 16'(QUIET_SAS_CYCLES - 1);

   localparam logic [9:0] SYM_ALT   = 10'b0101010101;
   localparam logic [9:0] SYM_P0_RP = 10'b1100000101;
   localparam logic [9:0] SYM_P1_RP = 10'b1101100011;
   localparam logic [9:0] SYM_P0_RN = 10'b0011111010;
   localparam logic [9:0] SYM_P1_RN = 10'b0010011100;

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [3:0]    burst_cnt_q, burst_cnt_d;
   logic [15:0]   sw_q, sw_d;
   logic          phase_q, phase_d;
   logic          outval_q, outval_d;
   logic          busy_q, busy_d;
   logic          finish_q, finish_d;
   logic          txelecidle_q, txelecidle_d;
   logic [15:0]   quiet_last;
   logic [19:0]   word0, word1;
   logic [width-1:0] burst_data;

   always_comb begin
      unique case (mode_q)
         MODE_INIT: quiet_last = QI_LAST;
         MODE_WAKE: quiet_last = QW_LAST;
         default:   quiet_last = QS_LAST;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (TXCOMINIT | TXCOMWAKE | TXCOMSAS) begin
               state_d = ST_BURST;
               if (TXCOMINIT)      mode_d = MODE_INIT;
               else if (TXCOMWAKE) mode_d = MODE_WAKE;
               else                mode_d = MODE_SAS;
            end
         end
         ST_BURST: begin
            if (sw_q == BURST_LAST) begin
               state_d     = ST_QUIET;
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end
         ST_QUIET: begin
            // every burst, including the last, is followed by a full quiet gap
            if (sw_q == quiet_last)
               state_d = (burst_cnt_q < SATA_BURST_SEQ_LEN) ? ST_BURST : ST_DONE;
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
            mode_d      = MODE_NONE;
         end
         default: state_d = ST_IDLE;
      endcase
      sw_d         = (state_d != state_q) ? '0 : sw_q + 16'd1;
      phase_d      = (state_q == ST_BURST && state_d == ST_BURST) ? ~phase_q : 1'b0;
      outval_d     = (state_d == ST_BURST);
      txelecidle_d = ~outval_d;
      busy_d       = (state_d != ST_IDLE);
      finish_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_NONE;
         burst_cnt_q  <= '0;
         sw_q         <= '0;
         phase_q      <= 1'b0;
         outval_q     <= 1'b0;
         txelecidle_q <= 1'b1;
         busy_q       <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         burst_cnt_q  <= burst_cnt_d;
         sw_q         <= sw_d;
         phase_q      <= phase_d;
         outval_q     <= outval_d;
         txelecidle_q <= txelecidle_d;
         busy_q       <= busy_d;
         finish_q     <= finish_d;
      end
   end

   always_comb begin
      word0 = disparity ? {SYM_ALT, SYM_P0_RP} : {SYM_ALT, SYM_P0_RN};
      word1 = disparity ? {SYM_P1_RP, SYM_ALT} : {SYM_P1_RN, SYM_ALT};
   end

   generate
      if (width == 20) begin : g_w20
         always_comb burst_data = phase_q ? word1 : word0;
      end else if (width == 40) begin : g_w40
         always_comb burst_data = {word1, word0};
      end else begin : g_bad
         $fatal(1, "gtxe2_chnl_tx_oob_gen: width must be 20 or 40");
      end
   endgenerate

   always_comb begin
      outdata     = outval_q ? burst_data : '0;
      outval      = outval_q;
      txelecidle  = txelecidle_q;
      busy        = busy_q;
      TXCOMFINISH = finish_q;
   end

endmodule
